// File: rtl/y_arith_seq.sv
// Registered ADD/SUB/SLT plus iterative shift-add MUL behind a valid/ready handshake.
// One op in flight; results and flags are held in DONE until the consumer takes them.
module y_arith_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [CW-1:0]        count_reg;

  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic                 ovf_add;
  logic                 ovf_sub;
  logic                 slt_bit;
  logic [2*WIDTH-1:0]   acc_next;

  assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid & in_ready;

  // Subtraction is a + ~b + 1 so bit WIDTH is the "no borrow" flag.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
  assign slt_bit = diff[WIDTH-1] ^ ovf_sub;

  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      z          <= '0;
      cout       <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST_ITER) begin
            state_reg <= DONE;
            count_reg <= '0;
            z         <= acc_next[WIDTH-1:0];
            cout      <= 1'b0;
            zero      <= (acc_next[WIDTH-1:0] == '0);
            ovf       <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: ;
      endcase

      // A new op can only be accepted in IDLE or while DONE hands off, never in MUL.
      if (accept) begin
        case (op)
          2'b00: begin
            state_reg <= DONE;
            z         <= sum[WIDTH-1:0];
            cout      <= sum[WIDTH];
            zero      <= (sum[WIDTH-1:0] == '0);
            ovf       <= ovf_add;
          end
          2'b01: begin
            state_reg <= DONE;
            z         <= diff[WIDTH-1:0];
            cout      <= diff[WIDTH];
            zero      <= (diff[WIDTH-1:0] == '0);
            ovf       <= ovf_sub;
          end
          2'b10: begin
            state_reg <= DONE;
            z         <= {{(WIDTH-1){1'b0}}, slt_bit};
            cout      <= diff[WIDTH];
            zero      <= ~slt_bit;
            ovf       <= 1'b0;
          end
          default: begin
            state_reg  <= MUL;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            count_reg  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_y_arith_seq.sv
// Self-checking bench for y_arith_seq (WIDTH=8): vector table, scoreboard queue,
// and hand-written sequences for backpressure, streaming and reset mid-MUL.
module tb_y_arith_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         cout, zero, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] z;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    logic         cout;
    logic         zero;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];

  y_arith_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: compare every handshaked result against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      exp_t got;
      checks++;
      got = '{z: z, cout: cout, zero: zero, ovf: ovf};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got z=0x%0h cout=%0b zero=%0b ovf=%0b, expected none",
                 z, cout, zero, ovf);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL result: got z=0x%0h cout=%0b zero=%0b ovf=%0b, expected z=0x%0h cout=%0b zero=%0b ovf=%0b",
                   z, cout, zero, ovf, e.z, e.cout, e.zero, e.ovf);
        end else begin
          $display("result z=0x%0h cout=%0b zero=%0b ovf=%0b ok", z, cout, zero, ovf);
        end
      end
    end
  end

  // Present an op, wait (bounded) for in_ready, return just after the accept edge.
  task automatic send(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int waited = 0;
    in_valid = 1'b1;
    op = o;
    a = aa;
    b = bb;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("sent op=%0d a=0x%0h b=0x%0h", o, aa, bb);
  endtask

  // Called just after the accept edge: count cycles until out_valid.
  task automatic wait_result(input int exp_lat, input bit is_mul);
    int lat = 1;
    bit ready_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 16'(lat), 16'(exp_lat));
    if (is_mul) check("in_ready_during_mul", {15'd0, ready_seen}, 16'd0);
  endtask

  initial begin
    //            op     a      b      z      cout  zero  ovf
    vecs[0]  = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{2'b10, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 8'h10, 8'h11, 8'h10, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 8'h00, 8'hAB, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{2'b01, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_in_ready", {15'd0, in_ready}, 16'd1);
    check("reset_z", {8'd0, z}, 16'd0);
    check("reset_flags", {13'd0, cout, zero, ovf}, 16'd0);
    reset = 1'b0;

    // Vector table, one op at a time with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sb.push_back('{z: vecs[i].z, cout: vecs[i].cout, zero: vecs[i].zero, ovf: vecs[i].ovf});
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result(vecs[i].op == 2'b11 ? W + 1 : 1, vecs[i].op == 2'b11);
      @(posedge clk);
      #1;
    end

    // Backpressure: result held for 5 cycles, then handed off alongside a new ADD.
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    sb.push_back('{z: 8'h07, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 8'h03, 8'h04);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
      check("bp_z_held", {8'd0, z}, 16'h0007);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    sb.push_back('{z: 8'h02, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 8'h01, 8'h01);
    check("bp_next_valid", {15'd0, out_valid}, 16'd1);
    check("bp_next_z", {8'd0, z}, 16'h0002);
    @(posedge clk);
    #1;

    // Streaming: four ADDs accepted on consecutive edges, each valid the next cycle.
    sb.push_back('{z: 8'h30, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 8'h10, 8'h20);
    check("stream_valid_0", {15'd0, out_valid}, 16'd1);
    sb.push_back('{z: 8'h03, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 8'h01, 8'h02);
    check("stream_valid_1", {15'd0, out_valid}, 16'd1);
    sb.push_back('{z: 8'h01, cout: 1'b1, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 8'hFE, 8'h03);
    check("stream_valid_2", {15'd0, out_valid}, 16'd1);
    sb.push_back('{z: 8'h80, cout: 1'b0, zero: 1'b0, ovf: 1'b1});
    send(2'b00, 8'h40, 8'h40);
    check("stream_valid_3", {15'd0, out_valid}, 16'd1);
    @(posedge clk);
    #1;
    check("stream_drained", {15'd0, out_valid}, 16'd0);

    // Reset sampled on the 4th MUL iteration edge discards the op.
    send(2'b11, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mul_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_mul_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_mul_z", {8'd0, z}, 16'd0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1'b1;
      end
      check("rst_mul_no_emit", {15'd0, seen}, 16'd0);
    end

    sb.push_back('{z: 8'h0A, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 8'h05, 8'h05);
    wait_result(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
